// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with rotate modes, status flags, valid/ready backpressure
// and a pass-through tag. The shift amount bits are applied across STAGES register stages.
module shift_unit_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAGW   = 4,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [TAGW-1:0]  out_tag
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SLA = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [2:0]       op;
    logic [TAGW-1:0]  tag;
    logic             sign;
    logic             carry;
    logic             ovf;
    logic             illegal;
    logic             zero;
  } stage_t;

  stage_t              stage_q [STAGES];
  stage_t              stage_d [STAGES];
  stage_t              feed_c  [STAGES];
  stage_t              entry_c;
  logic [STAGES-1:0]   valid_q;
  logic [STAGES-1:0]   valid_d;
  logic [STAGES-1:0]   vchain_c;
  logic [STAGES:0]     take_c;
  logic [WIDTH-1:0]    shl_c;
  logic [SHW-1:0]      lidx_c;
  logic [SHW-1:0]      ridx_c;

  // Applies the amount bits owned by stage s; the last stage also restores the SLA sign and sets zero.
  function automatic stage_t step(input stage_t p, input int unsigned s);
    stage_t r;
    r = p;
    for (int unsigned b = 0; b < SHW; b++) begin
      if (((b * STAGES) / SHW) == s && r.amt[b] && !r.illegal) begin
        case (r.op)
          OP_SLL, OP_SLA: r.data = r.data << (32'd1 << b);
          OP_SRL:         r.data = r.data >> (32'd1 << b);
          OP_SRA:         r.data = WIDTH'($signed(r.data) >>> (32'd1 << b));
          OP_ROL:         r.data = (r.data << (32'd1 << b)) | (r.data >> (WIDTH - (32'd1 << b)));
          OP_ROR:         r.data = (r.data >> (32'd1 << b)) | (r.data << (WIDTH - (32'd1 << b)));
          default:        r.data = r.data;
        endcase
      end
    end
    if (s == STAGES - 1) begin
      if (r.op == OP_SLA && !r.illegal) r.data[WIDTH-1] = r.sign;
      r.zero = (r.data == '0);
    end
    return r;
  endfunction

  // Carry and overflow depend only on the original operand, so they are resolved on entry.
  always_comb begin
    shl_c         = in_data << in_amt;
    lidx_c        = SHW'(WIDTH - 32'(in_amt));
    ridx_c        = in_amt - SHW'(1);
    entry_c       = '0;
    entry_c.data  = in_data;
    entry_c.amt   = in_amt;
    entry_c.op    = in_op;
    entry_c.tag   = in_tag;
    entry_c.sign  = in_data[WIDTH-1];
    entry_c.illegal = in_op[2] & in_op[1];
    if (in_amt != '0) begin
      case (in_op)
        OP_SLL, OP_SLA, OP_ROL: entry_c.carry = in_data[lidx_c];
        OP_SRL, OP_SRA, OP_ROR: entry_c.carry = in_data[ridx_c];
        default:                entry_c.carry = 1'b0;
      endcase
    end
    entry_c.ovf = (in_op == OP_SLA) && (WIDTH'($signed(shl_c) >>> in_amt) != in_data);
  end

  // A stage can take new content when it is empty or its content is leaving.
  always_comb begin
    take_c         = '0;
    take_c[STAGES] = out_ready;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      take_c[s] = ~valid_q[s] | take_c[s+1];
    end
    vchain_c = STAGES'({valid_q, in_valid});
    valid_d  = valid_q;
    for (int s = 0; s < int'(STAGES); s++) begin
      if (take_c[s]) valid_d[s] = vchain_c[s];
    end
  end

  always_comb begin
    feed_c[0] = entry_c;
    for (int s = 1; s < int'(STAGES); s++) begin
      feed_c[s] = stage_q[s-1];
    end
  end

  always_comb begin
    for (int s = 0; s < int'(STAGES); s++) begin
      stage_d[s] = stage_q[s];
      if (take_c[s] && vchain_c[s]) stage_d[s] = step(feed_c[s], 32'(s));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  assign in_ready    = take_c[0];
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = stage_q[STAGES-1].data;
  assign out_carry   = stage_q[STAGES-1].carry;
  assign out_zero    = stage_q[STAGES-1].zero;
  assign out_ovf     = stage_q[STAGES-1].ovf;
  assign out_illegal = stage_q[STAGES-1].illegal;
  assign out_tag     = stage_q[STAGES-1].tag;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed cases, backpressure and reset on a 32/2 instance,
// randomized traffic on 32/2, 8/1 and 64/6 instances against a bit-level reference model.
module tb_shift_unit_pipe;

  localparam int NI = 3;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  flags;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clock;
  logic        reset;
  int          cyc;
  logic        iv [NI];
  logic        ir [NI];
  logic        ov [NI];
  logic        ordy [NI];
  logic [63:0] idat [NI];
  logic [5:0]  iamt [NI];
  logic [2:0]  iop [NI];
  logic [3:0]  itag [NI];
  logic [63:0] odat [NI];
  logic        oc [NI];
  logic        oz [NI];
  logic        oo [NI];
  logic        oi [NI];
  logic [3:0]  otag [NI];
  logic [31:0] od0;
  logic [7:0]  od1;
  logic [63:0] od2;
  bit          latmode [NI];

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t fifo [NI][16];
  int   wr [NI];
  int   rd [NI];
  bit   held [NI];
  logic [63:0] pdat [NI];
  logic [63:0] pmeta [NI];

  assign odat[0] = 64'(od0);
  assign odat[1] = 64'(od1);
  assign odat[2] = od2;

  shift_unit_pipe #(.WIDTH(32), .STAGES(2), .TAGW(4)) u_w32 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0][31:0]),
    .in_amt(iamt[0][4:0]), .in_op(iop[0]), .in_tag(itag[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od0), .out_carry(oc[0]), .out_zero(oz[0]), .out_ovf(oo[0]), .out_illegal(oi[0]),
    .out_tag(otag[0]));

  shift_unit_pipe #(.WIDTH(8), .STAGES(1), .TAGW(4)) u_w8 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1][7:0]),
    .in_amt(iamt[1][2:0]), .in_op(iop[1]), .in_tag(itag[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od1), .out_carry(oc[1]), .out_zero(oz[1]), .out_ovf(oo[1]), .out_illegal(oi[1]),
    .out_tag(otag[1]));

  shift_unit_pipe #(.WIDTH(64), .STAGES(6), .TAGW(4)) u_w64 (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
    .in_amt(iamt[2]), .in_op(iop[2]), .in_tag(itag[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od2), .out_carry(oc[2]), .out_zero(oz[2]), .out_ovf(oo[2]), .out_illegal(oi[2]),
    .out_tag(otag[2]));

  function automatic int wof(input int k);
    case (k)
      0:       return 32;
      1:       return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int sof(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 6;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Result of one operation, built bit by bit from the shift/rotate definitions.
  function automatic exp_t model(input int w, input logic [2:0] op, input logic [63:0] xin,
                                 input int amt, input logic [3:0] tag);
    exp_t e;
    logic [63:0] x;
    logic [63:0] r;
    logic c, ovf, ill;
    x   = (w == 64) ? xin : (xin & ((64'd1 << w) - 64'd1));
    r   = '0;
    c   = 1'b0;
    ovf = 1'b0;
    ill = (op >= 3'd6);
    if (ill) begin
      r = x;
    end else begin
      for (int j = 0; j < w; j++) begin
        case (op)
          3'd0:    r[j] = (j >= amt) ? x[j-amt] : 1'b0;
          3'd1:    r[j] = (j == w-1) ? x[w-1] : ((j >= amt) ? x[j-amt] : 1'b0);
          3'd2:    r[j] = (j + amt < w) ? x[j+amt] : 1'b0;
          3'd3:    r[j] = (j + amt < w) ? x[j+amt] : x[w-1];
          3'd4:    r[j] = x[(j - amt + w) % w];
          default: r[j] = x[(j + amt) % w];
        endcase
      end
      if (amt != 0) c = (op == 3'd0 || op == 3'd1 || op == 3'd4) ? x[w-amt] : x[amt-1];
      if (op == 3'd1) begin
        for (int j = w - 1 - amt; j < w; j++) if (x[j] != x[w-1]) ovf = 1'b1;
      end
    end
    e.data  = r;
    e.flags = {c, (r == 64'd0), ovf, ill};
    e.tag   = tag;
    e.cyc   = 0;
    e.lat   = 1'b0;
    return e;
  endfunction

  initial begin
    clock = 1'b0;
    cyc   = 0;
    forever begin
      #5 clock = ~clock;
      if (clock) cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: records every input transfer and matches every output transfer in order.
  initial begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      wr[k] = 0; rd[k] = 0; held[k] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
        if (reset) begin
          rd[k]   = wr[k];
          held[k] = 1'b0;
        end else begin
          if (held[k]) begin
            check($sformatf("hold_data%0d", k), odat[k], pdat[k]);
            check($sformatf("hold_meta%0d", k), 64'({oc[k], oz[k], oo[k], oi[k], otag[k], ov[k]}), pmeta[k]);
          end
          if (ov[k] && ordy[k]) begin
            if (rd[k] == wr[k]) begin
              check($sformatf("unexpected_out%0d", k), 64'(ov[k]), 64'd0);
            end else begin
              e = fifo[k][rd[k] % 16];
              rd[k]++;
              check($sformatf("data%0d", k), odat[k], e.data);
              check($sformatf("flags%0d", k), 64'({oc[k], oz[k], oo[k], oi[k]}), 64'(e.flags));
              check($sformatf("tag%0d", k), 64'(otag[k]), 64'(e.tag));
              if (e.lat) check($sformatf("latency%0d", k), 64'(cyc - e.cyc), 64'(sof(k)));
            end
          end
          if (iv[k] && ir[k]) begin
            e     = model(wof(k), iop[k], idat[k], int'(iamt[k]), itag[k]);
            e.cyc = cyc;
            e.lat = latmode[k];
            fifo[k][wr[k] % 16] = e;
            wr[k]++;
          end
          held[k]  = ov[k] && !ordy[k];
          pdat[k]  = odat[k];
          pmeta[k] = 64'({oc[k], oz[k], oo[k], oi[k], otag[k], ov[k]});
        end
      end
    end
  end

  task automatic new_op(input int k, input logic [3:0] tag);
    idat[k] = {$urandom(), $urandom()};
    iop[k]  = 3'($urandom_range(0, 7));
    iamt[k] = ($urandom_range(0, 3) == 0) ? 6'(wof(k) - 1) : 6'($urandom_range(0, wof(k) - 1));
    itag[k] = tag;
  endtask

  task automatic dir_op(input string nm, input logic [2:0] op, input logic [31:0] x, input int amt,
                        input logic [31:0] ed, input logic [3:0] ef);
    @(posedge clock); #1;
    iv[0] = 1'b1; iop[0] = op; idat[0] = 64'(x); iamt[0] = 6'(amt); itag[0] = 4'(op); ordy[0] = 1'b1;
    @(negedge clock);
    check($sformatf("%s_rdy", nm), 64'(ir[0]), 64'd1);
    @(posedge clock); #1;
    iv[0] = 1'b0;
    @(negedge clock);
    check($sformatf("%s_early", nm), 64'(ov[0]), 64'd0);
    @(negedge clock);
    check($sformatf("%s_valid", nm), 64'(ov[0]), 64'd1);
    check($sformatf("%s_data", nm), odat[0], 64'(ed));
    check($sformatf("%s_flags", nm), 64'({oc[0], oz[0], oo[0], oi[0]}), 64'(ef));
  endtask

  task automatic rand_run(input int k, input int n);
    bit acc;
    latmode[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      ordy[k] = 1'b1;
      iv[k]   = ($urandom_range(0, 9) < 7);
      new_op(k, 4'($urandom()));
    end
    @(posedge clock); #1;
    iv[k] = 1'b0;
    repeat (sof(k) + 2) @(posedge clock);
    #1;
    latmode[k] = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (!iv[k] || acc) begin
        iv[k] = ($urandom_range(0, 9) < 7);
        new_op(k, 4'($urandom()));
      end
      ordy[k] = ($urandom_range(0, 9) < 6);
      @(negedge clock);
      acc = iv[k] && ir[k];
    end
    @(posedge clock); #1;
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    repeat (sof(k) + 3) @(posedge clock);
  endtask

  initial begin
    bit acc;
    int sent;
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; idat[k] = '0; iamt[k] = '0; iop[k] = '0; itag[k] = '0;
      latmode[k] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid%0d", k), 64'(ov[k]), 64'd0);
      check($sformatf("rst_ready%0d", k), 64'(ir[k]), 64'd1);
      check($sformatf("rst_data%0d", k), odat[k], 64'd0);
      check($sformatf("rst_meta%0d", k), 64'({oc[k], oz[k], oo[k], oi[k], otag[k]}), 64'd0);
    end

    dir_op("sll31",   3'd0, 32'h0000_0001, 31, 32'h8000_0000, 4'b0000);
    dir_op("sra4",    3'd3, 32'h8000_0010, 4,  32'hF800_0001, 4'b0000);
    dir_op("ror1",    3'd5, 32'h0000_0003, 1,  32'h8000_0001, 4'b1000);
    dir_op("rol1",    3'd4, 32'h8000_0000, 1,  32'h0000_0001, 4'b1000);
    dir_op("srl1",    3'd2, 32'h0000_0001, 1,  32'h0000_0000, 4'b1100);
    dir_op("sla_ovf", 3'd1, 32'h4000_0000, 1,  32'h0000_0000, 4'b0110);
    dir_op("sla_ok",  3'd1, 32'hC000_0000, 1,  32'h8000_0000, 4'b1000);
    dir_op("sla_a0",  3'd1, 32'h4000_0000, 0,  32'h4000_0000, 4'b0000);
    dir_op("ror_a0",  3'd5, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 4'b0000);
    dir_op("ill6",    3'd6, 32'h1234_5678, 5,  32'h1234_5678, 4'b0001);
    dir_op("ill7z",   3'd7, 32'h0000_0000, 3,  32'h0000_0000, 4'b0101);

    // Backpressure: tags 0..7 back-to-back, consumer stalls for cycles 3..7.
    sent = 0;
    acc  = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clock); #1;
      if (acc) sent++;
      iv[0] = (sent < 8);
      if (acc || c == 0) new_op(0, 4'(sent));
      ordy[0] = !(c >= 3 && c <= 7);
      @(negedge clock);
      acc = iv[0] && ir[0];
      if (c >= 3 && c <= 7) check($sformatf("bp_inready_c%0d", c), 64'(ir[0]), 64'd0);
      if (c >= 8 && c <= 14) check($sformatf("bp_thru_c%0d", c), 64'(ov[0]), 64'd1);
      if (c == 15) check("bp_empty", 64'(ov[0]), 64'd0);
    end
    check("bp_sent", 64'(sent), 64'd8);

    // Reset with two operations in flight discards both.
    @(posedge clock); #1;
    ordy[0] = 1'b0; iv[0] = 1'b1; new_op(0, 4'hA);
    @(negedge clock);
    check("rf_rdyA", 64'(ir[0]), 64'd1);
    @(posedge clock); #1;
    new_op(0, 4'hB);
    @(negedge clock);
    check("rf_rdyB", 64'(ir[0]), 64'd1);
    @(posedge clock); #1;
    iv[0] = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; ordy[0] = 1'b1;
    @(negedge clock);
    check("rf_valid", 64'(ov[0]), 64'd0);
    check("rf_ready", 64'(ir[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("rf_quiet%0d", i), 64'(ov[0]), 64'd0);
    end

    for (int k = 0; k < NI; k++) rand_run(k, 300);

    for (int k = 0; k < NI; k++) check($sformatf("drained%0d", k), 64'(wr[k] - rd[k]), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
